reg_reclaim_sched: RTL and testbench
====================================

REG_RECLAIM_SCHED -- requirements
Module: reg_reclaim_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 7, physical-register tag width.
REQ-002 SHALL have parameter BUF_DEPTH, default 4, reclaim buffer entries; legal values: power of two, >= 2.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, consecutive blocked cycles before squash is forced through.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have ports commit_valid_1 / commit_valid_2  input  1  commit release slot valid.
REQ-007 SHALL have ports commit_reg_1 / commit_reg_2  input  DATA_WIDTH  released tag per slot.
REQ-008 SHALL have port commit_ready  output  1  both commit slots accepted this cycle.
REQ-009 SHALL have ports squash_valid input 1, squash_reg input DATA_WIDTH, squash_ready output 1: single-tag release from the misprediction walker.
REQ-010 SHALL have ports fl_push output 1, fl_push_data output DATA_WIDTH, fl_ready input 1: connection to the free list push channel.
REQ-011 SHALL have port pending_cnt  output  $clog2(BUF_DEPTH)+1  buffer occupancy.

Function
REQ-012 SHALL accept a commit transfer when any commit_valid_x is high and commit_ready is high.
REQ-013 SHALL accept a squash transfer when squash_valid and squash_ready are both high.
REQ-014 SHALL compute free = BUF_DEPTH - pending_cnt from registered state only; a same-cycle drain does not add space.
REQ-015 SHALL drive commit_ready = (free >= 2) and not force_squash.
REQ-016 SHALL drive squash_ready = (free >= 1) and (no commit_valid_x high, or force_squash).
REQ-017 SHALL write an accepted commit in slot order (slot 1 first); a lone commit_valid_2 SHALL be written as a single entry.
REQ-018 SHALL never accept commit and squash in the same cycle.
REQ-019 SHALL keep starve_cnt, incremented each cycle squash_valid is high and squash is not accepted, cleared on squash acceptance or when squash_valid is low.
REQ-020 SHALL assert force_squash when starve_cnt == STARVE_LIMIT, and hold it until the squash is accepted.
REQ-021 SHALL drive fl_push = (pending_cnt != 0) and fl_ready, with fl_push_data = head entry; head advances on fl_push.
REQ-022 SHALL provide a one-cycle latency from acceptance to the earliest fl_push.
REQ-023 SHALL support enqueue (up to 2) and dequeue (1) in the same cycle: pending_cnt_next = pending_cnt + writes - drain.
REQ-024 SHALL wrap read/write pointers modulo BUF_DEPTH.
REQ-025 SHALL drive fl_push low whenever fl_ready is low; entries SHALL be held, not dropped.

Reset
REQ-026 SHALL, on rst high at a clk edge, clear pointers, pending_cnt, starve_cnt and force_squash, discarding buffered entries.
REQ-027 SHALL, after reset, output fl_push=0, pending_cnt=0, commit_ready=1, and squash_ready=1 when no commit is valid.
REQ-028 SHALL let reset asserted mid-transfer override every same-cycle acceptance and drain.

Configuration
REQ-029 SHALL support macro FL_RECLAIM_BYPASS_EN.
REQ-030 With FL_RECLAIM_BYPASS_EN defined, when pending_cnt==0 and fl_ready, SHALL push the first accepted tag in the same cycle (commit slot 1, else squash), not write it to the buffer, and buffer only the remainder.
REQ-031 Without FL_RECLAIM_BYPASS_EN, SHALL push nothing earlier than one cycle after acceptance.

Structure
REQ-032 SHALL take phys_reg_t (logic[DATA_WIDTH-1:0]) and the reclaim parameter defaults from the shared rename package.
REQ-033 SHALL instantiate one sub-module reclaim_buffer: a circular FIFO with 2 write ports and 1 read port, exposing count.
REQ-034 SHALL keep arbitration, starvation and bypass logic in reg_reclaim_sched.

Verification
REQ-035 The bench SHALL cover: reset, then commit (5,9) both valid with fl_ready=1 -> cycle+1 push 5, cycle+2 push 9, pending_cnt returns to 0.
REQ-036 The bench SHALL cover: fl_ready=0, two commits (1,2),(3,4) -> pending_cnt=4, commit_ready=0, squash_ready=0; then fl_ready=1 -> pushes 1,2,3,4 in order.
REQ-037 The bench SHALL cover: squash_valid with reg 20 and commit_valid_1 held high continuously -> squash accepted on the 4th blocked cycle (STARVE_LIMIT=3), commit_ready=0 that cycle.
REQ-038 The bench SHALL cover: lone commit_valid_2 with reg 7 -> exactly one entry written, push 7.
REQ-039 The bench SHALL cover: rst asserted with pending_cnt=3 -> next cycle pending_cnt=0, fl_push=0, no stale tag pushed.
REQ-040 The bench SHALL cover: with FL_RECLAIM_BYPASS_EN, empty buffer, fl_ready=1, commit (11,12) -> push 11 same cycle, push 12 next cycle.

Source files
------------

// File: rtl/reg_reclaim_sched_pkg.sv
// Shared rename package: physical-register tag type, reclaim defaults and
// the starvation FSM state encoding used by reg_reclaim_sched.
package reg_reclaim_sched_pkg;

  localparam int DEF_DATA_WIDTH   = 7;
  localparam int DEF_BUF_DEPTH    = 4;
  localparam int DEF_STARVE_LIMIT = 3;

  typedef logic [DEF_DATA_WIDTH-1:0] phys_reg_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } starve_state_t;

  // Occupancy needs one extra bit so a full buffer is distinguishable from empty.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_reclaim_sched_if.sv
// Handshake bundle between the commit/squash release sources, the reclaim
// scheduler and the free-list push channel.
interface reg_reclaim_sched_if
  import reg_reclaim_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
);
  logic                        commit_valid_1;
  logic                        commit_valid_2;
  logic [DATA_WIDTH-1:0]       commit_reg_1;
  logic [DATA_WIDTH-1:0]       commit_reg_2;
  logic                        commit_ready;
  logic                        squash_valid;
  logic [DATA_WIDTH-1:0]       squash_reg;
  logic                        squash_ready;
  logic                        fl_push;
  logic [DATA_WIDTH-1:0]       fl_push_data;
  logic                        fl_ready;
  logic [cnt_width(BUF_DEPTH)-1:0] pending_cnt;

  modport master (
    output commit_valid_1, commit_valid_2, commit_reg_1, commit_reg_2,
    input  commit_ready,
    output squash_valid, squash_reg,
    input  squash_ready,
    input  fl_push, fl_push_data,
    output fl_ready,
    input  pending_cnt
  );

  modport slave (
    input  commit_valid_1, commit_valid_2, commit_reg_1, commit_reg_2,
    output commit_ready,
    input  squash_valid, squash_reg,
    output squash_ready,
    output fl_push, fl_push_data,
    input  fl_ready,
    output pending_cnt
  );
endinterface

// File: rtl/reclaim_buffer.sv
// Circular reclaim FIFO: two write ports (port 1 only used together with
// port 0, landing in the slot after it), one read port, exposed occupancy.
module reclaim_buffer
  import reg_reclaim_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_BUF_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en0,
  input  logic [DATA_WIDTH-1:0]           wr_data0,
  input  logic                            wr_en1,
  input  logic [DATA_WIDTH-1:0]           wr_data1,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [cnt_width(DEPTH)-1:0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_en0) + PW'(wr_en1);
      rd_ptr <= rd_ptr + PW'(rd_en);
      count  <= count + CW'(wr_en0) + CW'(wr_en1) - CW'(rd_en);
    end
  end

  // Entry storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_ptr] <= wr_data0;
    if (wr_en1) mem[wr_ptr + PW'(1)] <= wr_data1;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/reg_reclaim_sched.sv
// Physical-register reclaim scheduler: merges two commit release slots and a
// squash walker release into the free-list push channel through a small
// buffer, with a starvation guard that eventually forces squash through.
// Optional macro FL_RECLAIM_BYPASS_EN: when the buffer is empty and the free
// list is ready, the first accepted tag is pushed in the acceptance cycle.
//
// Starvation FSM
//   state     | meaning
//   ST_NORMAL | commits have priority over squash
//   ST_FORCE  | squash starved STARVE_LIMIT cycles; commits held off until it is accepted
module reg_reclaim_sched
  import reg_reclaim_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic               clk,
  input  logic               rst,
  reg_reclaim_sched_if.slave bus
);
  localparam int CNT_W = cnt_width(BUF_DEPTH);
  localparam int SW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      free;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] first_tag;
  logic [DATA_WIDTH-1:0] second_tag;
  logic [DATA_WIDTH-1:0] wr_data0;
  logic [DATA_WIDTH-1:0] wr_data1;
  logic                  any_commit;
  logic                  commit_ready_c;
  logic                  squash_ready_c;
  logic                  commit_acc;
  logic                  squash_acc;
  logic                  two_tags;
  logic                  drain;
  logic                  bypass;
  logic                  wr_en0;
  logic                  wr_en1;
  logic                  force_squash;
  starve_state_t         state;
  starve_state_t         state_next;
  logic [SW-1:0]         starve_cnt;
  logic [SW-1:0]         starve_next;

  // Space is judged on registered occupancy only; a same-cycle drain does not help.
  assign free = CNT_W'(BUF_DEPTH) - count;

  // Arbitration: commits win unless squash has starved; reset blocks all acceptance.
  always_comb begin
    any_commit     = bus.commit_valid_1 | bus.commit_valid_2;
    commit_ready_c = !rst && (free >= CNT_W'(2)) && !force_squash;
    squash_ready_c = !rst && (free >= CNT_W'(1)) && (!any_commit || force_squash);
    commit_acc     = any_commit && commit_ready_c;
    squash_acc     = bus.squash_valid && squash_ready_c;
    first_tag      = commit_acc ? (bus.commit_valid_1 ? bus.commit_reg_1 : bus.commit_reg_2)
                                : bus.squash_reg;
    second_tag     = bus.commit_reg_2;
    two_tags       = commit_acc && bus.commit_valid_1 && bus.commit_valid_2;
    drain          = !rst && (count != '0) && bus.fl_ready;
  end

`ifdef FL_RECLAIM_BYPASS_EN
  assign bypass = !rst && (count == '0) && bus.fl_ready && (commit_acc || squash_acc);
`else
  assign bypass = 1'b0;
`endif

  // Buffer writes: compacted so port 0 always carries the oldest remaining tag.
  always_comb begin
    wr_en0   = 1'b0;
    wr_en1   = 1'b0;
    wr_data0 = first_tag;
    wr_data1 = second_tag;
    if (bypass) begin
      wr_en0   = two_tags;
      wr_data0 = second_tag;
    end else begin
      wr_en0 = commit_acc || squash_acc;
      wr_en1 = two_tags;
    end
  end

  // Starvation state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Starvation next state: count blocked squash cycles, saturating at the limit.
  always_comb begin
    starve_next = '0;
    if (bus.squash_valid && !squash_acc) begin
      starve_next = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
    end
    state_next = state;
    case (state)
      ST_NORMAL: if (bus.squash_valid && !squash_acc && starve_next == SW'(STARVE_LIMIT))
                   state_next = ST_FORCE;
      ST_FORCE:  if (squash_acc) state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
  end

  // Starvation outputs.
  always_comb begin
    force_squash = (state == ST_FORCE);
  end

  reclaim_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_reclaim_buffer (
    .clk      (clk),
    .rst      (rst),
    .wr_en0   (wr_en0),
    .wr_data0 (wr_data0),
    .wr_en1   (wr_en1),
    .wr_data1 (wr_data1),
    .rd_en    (drain),
    .rd_data  (head),
    .count    (count)
  );

  assign bus.commit_ready = commit_ready_c;
  assign bus.squash_ready = squash_ready_c;
  assign bus.fl_push      = drain | bypass;
  assign bus.fl_push_data = bypass ? first_tag : head;
  assign bus.pending_cnt  = count;

endmodule

// File: tb/tb_reg_reclaim_sched.sv
// Directed scoreboard bench for reg_reclaim_sched.
module tb_reg_reclaim_sched;
  import reg_reclaim_sched_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int BD = DEF_BUF_DEPTH;
  localparam int SL = DEF_STARVE_LIMIT;
`ifdef FL_RECLAIM_BYPASS_EN
  localparam logic [31:0] BYP = 32'd1;
`else
  localparam logic [31:0] BYP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  phys_reg_t   exp_q[$];
  logic [31:0] mon_exp;

  reg_reclaim_sched_if #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) bus ();

  reg_reclaim_sched #(
    .DATA_WIDTH   (DW),
    .BUF_DEPTH    (BD),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input int a, input logic v2, input int b,
                       input logic sv, input int s);
    bus.commit_valid_1 = v1;
    bus.commit_reg_1   = phys_reg_t'(a);
    bus.commit_valid_2 = v2;
    bus.commit_reg_2   = phys_reg_t'(b);
    bus.squash_valid   = sv;
    bus.squash_reg     = phys_reg_t'(s);
  endtask

  // Every free-list push must match the oldest expected tag; an unexpected push compares against X.
  always @(negedge clk) begin
    if (bus.fl_push === 1'b1) begin
      if (exp_q.size() != 0) mon_exp = 32'(exp_q.pop_front());
      else                   mon_exp = 'x;
      chk("push_data", 32'(bus.fl_push_data), mon_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.fl_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fl_push",      32'(bus.fl_push),      32'd0);
    chk("rst_pending",      32'(bus.pending_cnt),  32'd0);
    chk("rst_commit_ready", 32'(bus.commit_ready), 32'd1);
    chk("rst_squash_ready", 32'(bus.squash_ready), 32'd1);

    // Commit pair (5,9) with free list ready.
    step();
    bus.fl_ready = 1'b1;
    drive(1, 5, 1, 9, 0, 0);
    exp_q.push_back(phys_reg_t'(5));
    exp_q.push_back(phys_reg_t'(9));
    @(negedge clk);
    chk("s1_commit_ready", 32'(bus.commit_ready), 32'd1);
    chk("s1_push_at_acc",  32'(bus.fl_push),      BYP);
    step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s1_pending_c1", 32'(bus.pending_cnt), (BYP != 0) ? 32'd1 : 32'd2);
    chk("s1_push_c1",    32'(bus.fl_push),     32'd1);
    step();
    @(negedge clk);
    chk("s1_pending_c2", 32'(bus.pending_cnt), (BYP != 0) ? 32'd0 : 32'd1);
    chk("s1_push_c2",    32'(bus.fl_push),     (BYP != 0) ? 32'd0 : 32'd1);
    step();
    @(negedge clk);
    chk("s1_pending_end", 32'(bus.pending_cnt), 32'd0);

    // Free list stalled: fill with (1,2),(3,4), then release.
    step();
    bus.fl_ready = 1'b0;
    drive(1, 1, 1, 2, 0, 0);
    exp_q.push_back(phys_reg_t'(1));
    exp_q.push_back(phys_reg_t'(2));
    @(negedge clk);
    chk("s2_cr_first", 32'(bus.commit_ready), 32'd1);
    step();
    drive(1, 3, 1, 4, 0, 0);
    exp_q.push_back(phys_reg_t'(3));
    exp_q.push_back(phys_reg_t'(4));
    @(negedge clk);
    chk("s2_cr_second", 32'(bus.commit_ready), 32'd1);
    step();
    drive(0, 0, 0, 0, 1, 21);
    @(negedge clk);
    chk("s2_pending_full", 32'(bus.pending_cnt),  32'd4);
    chk("s2_cr_full",      32'(bus.commit_ready), 32'd0);
    chk("s2_sr_full",      32'(bus.squash_ready), 32'd0);
    chk("s2_hold_push",    32'(bus.fl_push),      32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    bus.fl_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s2_drain_pending", 32'(bus.pending_cnt), 32'(4 - i));
      step();
    end
    @(negedge clk);
    chk("s2_pending_end", 32'(bus.pending_cnt), 32'd0);

    // Squash 20 against a continuous commit stream.
    for (int k = 0; k <= SL; k++) begin
      step();
      drive(1, 30 + k, 0, 0, 1, 20);
      if (k < SL) exp_q.push_back(phys_reg_t'(30 + k));
      else        exp_q.push_back(phys_reg_t'(20));
      @(negedge clk);
      chk("s3_squash_ready", 32'(bus.squash_ready), (k == SL) ? 32'd1 : 32'd0);
      chk("s3_commit_ready", 32'(bus.commit_ready), (k == SL) ? 32'd0 : 32'd1);
    end
    step();
    drive(1, 33, 0, 0, 0, 0);
    exp_q.push_back(phys_reg_t'(33));
    @(negedge clk);
    chk("s3_cr_after_force", 32'(bus.commit_ready), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    @(negedge clk);
    chk("s3_pending_end", 32'(bus.pending_cnt), 32'd0);

    // Lone slot-2 commit.
    step();
    drive(0, 0, 1, 7, 0, 0);
    exp_q.push_back(phys_reg_t'(7));
    @(negedge clk);
    chk("s4_commit_ready", 32'(bus.commit_ready), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s4_pending_one", 32'(bus.pending_cnt), (BYP != 0) ? 32'd0 : 32'd1);
    step();
    @(negedge clk);
    chk("s4_pending_end", 32'(bus.pending_cnt), 32'd0);

    // Reset with three buffered tags; none may ever reach the free list.
    step();
    bus.fl_ready = 1'b0;
    drive(1, 40, 1, 41, 0, 0);
    step();
    drive(1, 42, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s5_pending_three", 32'(bus.pending_cnt), 32'd3);
    step();
    rst = 1'b1;
    bus.fl_ready = 1'b1;
    drive(1, 43, 0, 0, 0, 0);
    @(negedge clk);
    chk("s5_push_in_rst", 32'(bus.fl_push), 32'd0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s5_pending_zero", 32'(bus.pending_cnt),  32'd0);
    chk("s5_no_push",      32'(bus.fl_push),      32'd0);
    chk("s5_cr_after",     32'(bus.commit_ready), 32'd1);
    repeat (3) step();

    // Commit (11,12) into an empty buffer with free list ready.
    drive(1, 11, 1, 12, 0, 0);
    exp_q.push_back(phys_reg_t'(11));
    exp_q.push_back(phys_reg_t'(12));
    @(negedge clk);
    chk("s6_push_at_acc", 32'(bus.fl_push), BYP);
    step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s6_push_c1", 32'(bus.fl_push), 32'd1);
    step();
    @(negedge clk);
    chk("s6_push_c2", 32'(bus.fl_push), (BYP != 0) ? 32'd0 : 32'd1);
    step();
    @(negedge clk);
    chk("s6_pending_end", 32'(bus.pending_cnt), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
